// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared types and helpers for the 7-segment scan controller.
//   scan_state_t : scan FSM state encoding (IDLE, BLANK, SHOW)
//   SEG_OFF      : all segments dark (active low)
//   hex2seg      : 4-bit hex digit -> active-low segments, bit order gfedcba
// ---------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low gfedcba patterns for the hex glyphs 0..F.
    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// ---------------------------------------------------------------------------
// seg7_hex_dec
// Combinational hex-to-segment decoder.
// Ports:
//   hex_i  in  4  hex digit
//   seg_o  out 7  segments gfedcba, active low
// ---------------------------------------------------------------------------
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex2seg(hex_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a common-anode 7-segment display bank.
// Latches an N-digit hex value at each frame start and steps through the
// digits one slot at a time. Each slot starts with BLANK_CYC clocks of all
// anodes off to suppress ghosting, then lights one digit for the rest of the
// DIV-clock slot.
//
// Ports:
//   clk         in   1    system clock, rising edge
//   rst         in   1    asynchronous active-high reset
//   en          in   1    scan enable; low forces IDLE (display dark)
//   value       in   4*N  hex digits, digit k = value[4k+3:4k]
//   load        in   1    strobe: capture value into the shadow register
//   an          out  N    anode select, active low, one-hot or all ones
//   seg         out  7    segments gfedcba, active low
//   frame_done  out  1    pulse during the last clock of the last slot
//   state_dbg   out  2    current scan FSM state (scan_state_t encoding)
//
// Valid/ready: this block has no handshake. load is a single-clock strobe
// sampled on every rising edge; there is no back-pressure.
//
// Build option: define SEG7_LZB_EN for leading-zero blanking (a digit k > 0
// is held dark while digits k..N-1 of the frame value are all zero).
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N         = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [4*N-1:0] value,
    input  logic           load,
    output logic [N-1:0]   an,
    output logic [6:0]     seg,
    output logic           frame_done,
    output logic [1:0]     state_dbg
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

    scan_state_t    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [4*N-1:0] shadow_q, shadow_d;
    logic [4*N-1:0] disp_q, disp_d;
    logic [N-1:0]   an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           frame_done_q, frame_done_d;

    logic           frame_start;
    logic [3:0]     dig_hex;
    logic [6:0]     dig_seg;
    logic           dig_dark;

    // ------------------------------------------------------------------
    // Scan FSM: next state, slot counter, digit index, frame value
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        disp_d      = disp_q;
        frame_start = 1'b0;

        // load is honoured in every state; the last strobe wins.
        shadow_d = load ? value : shadow_q;

        if (!en) begin
            // Dropping en aborts the current slot from any state.
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = BLANK;
                    cnt_d       = '0;
                    idx_d       = '0;
                    frame_start = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d       = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // The frame value is only replaced at frame start so a frame never
        // mixes digits of two values. A load on that same clock bypasses
        // the shadow so the new value shows without a frame of delay.
        if (frame_start) begin
            disp_d = load ? value : shadow_q;
        end
    end

    // ------------------------------------------------------------------
    // Digit mux and decode. Outputs are computed from the next-state
    // values and registered, so an/seg line up with state_q exactly.
    // ------------------------------------------------------------------
    always_comb begin
        dig_hex = 4'h0;
        for (int k = 0; k < N; k++) begin
            if (idx_d == IW'(k)) begin
                dig_hex = disp_d[4*k +: 4];
            end
        end
    end

    seg7_hex_dec u_dec (
        .hex_i (dig_hex),
        .seg_o (dig_seg)
    );

`ifdef SEG7_LZB_EN
    // A digit above position 0 is dark when it and every higher digit are 0.
    always_comb begin
        dig_dark = 1'b0;
        for (int k = 1; k < N; k++) begin
            if (idx_d == IW'(k) && ((disp_d >> (4*k)) == '0)) begin
                dig_dark = 1'b1;
            end
        end
    end
`else
    assign dig_dark = 1'b0;
`endif

    always_comb begin
        an_d         = '1;
        seg_d        = SEG_OFF;
        frame_done_d = 1'b0;
        if (state_d == SHOW) begin
            if (!dig_dark) begin
                an_d  = ~(N'(1) << idx_d);
                seg_d = dig_seg;
            end
            frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with N=4, DIV=4, BLANK_CYC=1.
// Directed vector table for the first frame, hand sequences for the
// multi-cycle corners, then randomized traffic against a frame-position
// reference model. Honours SEG7_LZB_EN in its expectations.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int N         = 4;
    localparam int DIV       = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = N * DIV;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.N(N), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .value      (value),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // m_run = clocks since the current frame started (-1 when idle).
    int          m_run;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic model_reset();
        m_run    = -1;
        m_disp   = '0;
        m_shadow = '0;
    endtask

    task automatic model_edge(input logic e, input logic l, input logic [15:0] v);
        if (!e) begin
            m_run = -1;
        end else if (m_run < 0 || m_run == FRAME - 1) begin
            m_run  = 0;
            m_disp = l ? v : m_shadow;
        end else begin
            m_run = m_run + 1;
        end
        if (l) m_shadow = v;
    endtask

    // {an, seg, frame_done} expected after the latest edge.
    function automatic logic [31:0] model_out();
        int         slot;
        int         off;
        logic       lit;
        logic [3:0] a;
        logic [6:0] s;
        logic       fd;
        logic [3:0] dig;
        a  = 4'hF;
        s  = 7'h7F;
        fd = 1'b0;
        if (m_run >= 0) begin
            slot = m_run / DIV;
            off  = m_run % DIV;
            lit  = (off >= BLANK_CYC);
`ifdef SEG7_LZB_EN
            if (slot > 0 && (m_disp >> (4*slot)) == 16'h0) lit = 1'b0;
`endif
            dig = 4'(m_disp >> (4*slot));
            if (lit) begin
                a = ~(4'b0001 << slot);
                s = seg_tbl[dig];
            end
            fd = (m_run == FRAME - 1);
        end
        return {20'h0, a, s, fd};
    endfunction

    function automatic logic [31:0] outs();
        return {20'h0, an, seg, frame_done};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input logic e, input logic l, input logic [15:0] v);
        @(negedge clk);
        en    = e;
        load  = l;
        value = v;
        @(posedge clk);
        model_edge(e, l, v);
        #1;
    endtask

    task automatic step_chk(input string name, input logic e, input logic l, input logic [15:0] v);
        step(e, l, v);
        check(name, outs(), model_out());
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en;
        logic        load;
        logic [15:0] value;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic e, input logic l, input logic [15:0] v,
                                input logic [3:0] a, input logic [6:0] s, input logic fd);
        vec_t r;
        r.en = e; r.load = l; r.value = v; r.an = a; r.seg = s; r.fd = fd;
        return r;
    endfunction

    localparam logic [31:0] DARK = {20'h0, 4'hF, 7'h7F, 1'b0};

    logic [3:0] lit_mask;
    logic [3:0] exp_mask;

    initial begin
        // First frame of 1234 loaded from IDLE (bypass on the first edge).
        vecs[0]  = mk(1'b1, 1'b1, 16'h1234, 4'hF, 7'h7F, 1'b0);
        for (int i = 1; i <= 3; i++)   vecs[i] = mk(1'b1, 1'b0, 16'h1234, 4'hE, 7'h19, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 16'h1234, 4'hF, 7'h7F, 1'b0);
        for (int i = 5; i <= 7; i++)   vecs[i] = mk(1'b1, 1'b0, 16'h1234, 4'hD, 7'h30, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 16'h1234, 4'hF, 7'h7F, 1'b0);
        for (int i = 9; i <= 11; i++)  vecs[i] = mk(1'b1, 1'b0, 16'h1234, 4'hB, 7'h24, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 16'h1234, 4'hF, 7'h7F, 1'b0);
        for (int i = 13; i <= 14; i++) vecs[i] = mk(1'b1, 1'b0, 16'h1234, 4'h7, 7'h79, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 16'h1234, 4'h7, 7'h79, 1'b1);
        vecs[16] = mk(1'b1, 1'b0, 16'h1234, 4'hF, 7'h7F, 1'b0);

        // ---- 1: reset, then enable with value 0 and no load ----
        model_reset();
        rst = 1'b1; en = 1'b1; load = 1'b0; value = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), DARK);
        check("reset_state", {30'h0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 1'b0, 16'h0000);
        #1;
        check("first_blank", outs(), DARK);
        step(1'b1, 1'b0, 16'h0000);
        check("first_lit_zero", outs(), {20'h0, 4'hE, 7'h40, 1'b0});
        step(1'b0, 1'b0, 16'h0000);
        check("disable_dark", outs(), DARK);
        check("disable_state", {30'h0, state_dbg}, 32'd0);

        // ---- 2: directed first frame of 1234 ----
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].en, vecs[i].load, vecs[i].value);
            check($sformatf("vec%0d", i), outs(), {20'h0, vecs[i].an, vecs[i].seg, vecs[i].fd});
        end

        // ---- 3: load mid-frame, current frame keeps 1234 ----
        step_chk("midload", 1'b1, 1'b1, 16'hABCD);
        check("midload_old_digit", outs(), {20'h0, 4'hE, 7'h19, 1'b0});
        repeat (14) step_chk("midload_frame", 1'b1, 1'b0, 16'h0000);
        check("frame_done_16", {31'h0, frame_done}, 32'd1);
        step_chk("abcd_start", 1'b1, 1'b0, 16'h0000);
        step_chk("abcd_d0", 1'b1, 1'b0, 16'h0000);
        check("abcd_d0_seg", outs(), {20'h0, 4'hE, 7'h21, 1'b0});

        // ---- 4: load on the frame-start clock bypasses the shadow ----
        repeat (14) step_chk("abcd_frame", 1'b1, 1'b0, 16'h0000);
        check("abcd_frame_done", {31'h0, frame_done}, 32'd1);
        step_chk("bypass_start", 1'b1, 1'b1, 16'h5678);
        step_chk("bypass_d0", 1'b1, 1'b0, 16'h0000);
        check("bypass_d0_seg", outs(), {20'h0, 4'hE, 7'h00, 1'b0});

        // ---- 5: drop en during digit 2, re-enable, async reset ----
        repeat (8) step_chk("to_digit2", 1'b1, 1'b0, 16'h0000);
        check("digit2_lit", outs(), {20'h0, 4'hB, 7'h02, 1'b0});
        step_chk("en_drop", 1'b0, 1'b0, 16'h0000);
        check("en_drop_dark", outs(), DARK);
        step_chk("reen_blank", 1'b1, 1'b0, 16'h0000);
        check("reen_blank_dark", outs(), DARK);
        step_chk("reen_d0", 1'b1, 1'b0, 16'h0000);
        check("reen_d0_seg", outs(), {20'h0, 4'hE, 7'h00, 1'b0});
        repeat (2) step_chk("pre_rst", 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_outputs", outs(), DARK);
        check("async_rst_state", {30'h0, state_dbg}, 32'd0);
        en = 1'b0; load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // ---- 6: leading-zero blanking ----
        lit_mask = 4'h0;
        step_chk("lzb_0050", 1'b1, 1'b1, 16'h0050);
        lit_mask = lit_mask | ~an;
        for (int i = 1; i < FRAME; i++) begin
            step_chk("lzb_0050", 1'b1, 1'b0, 16'h0000);
            lit_mask = lit_mask | ~an;
        end
`ifdef SEG7_LZB_EN
        exp_mask = 4'b0011;
`else
        exp_mask = 4'b1111;
`endif
        check("lzb_0050_digits", {28'h0, lit_mask}, {28'h0, exp_mask});

        lit_mask = 4'h0;
        step_chk("lzb_0000", 1'b1, 1'b1, 16'h0000);
        lit_mask = lit_mask | ~an;
        for (int i = 1; i < FRAME; i++) begin
            step_chk("lzb_0000", 1'b1, 1'b0, 16'h0000);
            lit_mask = lit_mask | ~an;
        end
`ifdef SEG7_LZB_EN
        exp_mask = 4'b0001;
`else
        exp_mask = 4'b1111;
`endif
        check("lzb_0000_digits", {28'h0, lit_mask}, {28'h0, exp_mask});

        // ---- 7: randomized traffic against the model ----
        for (int i = 0; i < 800; i++) begin
            logic        r_en;
            logic        r_ld;
            logic [15:0] r_v;
            r_en = ($urandom_range(0, 15) != 0);
            r_ld = ($urandom_range(0, 5) == 0);
            r_v  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            step_chk("random", r_en, r_ld, r_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
